// File: rtl/counter_monitor_if.sv
// Bundle between the upstream counter and its monitor: the count value going in,
// and the decoded display plus sequence-health status coming back.
interface counter_monitor_if #(
  parameter int WRAP_W = 16
);
  logic [3:0]        q_in;
  logic [6:0]        seg;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              seq_err;
  logic [7:0]        err_cnt;
  logic              stall;
  logic [1:0]        state;

  // Counter side: supplies q_in, observes the monitor status.
  modport master (
    output q_in,
    input  seg, wrap_pulse, wrap_cnt, seq_err, err_cnt, stall, state
  );

  // Monitor side: consumes q_in, produces display and status.
  modport slave (
    input  q_in,
    output seg, wrap_pulse, wrap_cnt, seq_err, err_cnt, stall, state
  );
endinterface

// File: rtl/counter_monitor.sv
// Watches a 4-bit free-running count: drives a 7-segment digit, checks each step
// is +1 mod 16 / hold / restart-to-0, counts wraps and errors, flags a stalled count.
module counter_monitor #(
  parameter int STALL_LIMIT    = 8,
  parameter int WRAP_W         = 16,
  parameter int ALLOW_HOLD     = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              clr,
  counter_monitor_if.slave  mon
);

  localparam logic [1:0] ST_INIT  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_FAULT = 2'b10;

  localparam logic [6:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [7:0]        LIMIT    = 8'(STALL_LIMIT);
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
  localparam logic [7:0]        ERR_MAX  = 8'hFF;

  logic [1:0] state_q;
  logic [1:0] state_nxt;
  logic [3:0] q_d;
  logic [7:0] hold_run;

  logic       checking;
  logic       step_hold;
  logic       step_wrap;
  logic       step_inc;
  logic       step_restart;
  logic       step_legal;
  logic [8:0] hold_next;
  logic       stall_hit;

  // Active-high {g,f,e,d,c,b,a} hex glyphs, lowercase b and d.
  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0:    hex_decode = 7'h3F;
      4'h1:    hex_decode = 7'h06;
      4'h2:    hex_decode = 7'h5B;
      4'h3:    hex_decode = 7'h4F;
      4'h4:    hex_decode = 7'h66;
      4'h5:    hex_decode = 7'h6D;
      4'h6:    hex_decode = 7'h7D;
      4'h7:    hex_decode = 7'h07;
      4'h8:    hex_decode = 7'h7F;
      4'h9:    hex_decode = 7'h6F;
      4'hA:    hex_decode = 7'h77;
      4'hB:    hex_decode = 7'h7C;
      4'hC:    hex_decode = 7'h39;
      4'hD:    hex_decode = 7'h5E;
      4'hE:    hex_decode = 7'h79;
      default: hex_decode = 7'h71;
    endcase
  endfunction

  // Step classification against the previous sample; only meaningful outside INIT.
  always_comb begin
    checking     = (state_q == ST_RUN) || (state_q == ST_FAULT);
    step_hold    = (mon.q_in == q_d);
    step_wrap    = (q_d == 4'hF) && (mon.q_in == 4'h0);
    step_inc     = (q_d != 4'hF) && (mon.q_in == q_d + 4'd1);
    // Hold at 0 is excluded here so it is classified purely as a hold.
    step_restart = (mon.q_in == 4'h0) && (q_d != 4'hF) && (q_d != 4'h0);
    step_legal   = step_wrap || step_inc || step_restart ||
                   (step_hold && (ALLOW_HOLD != 0));
    hold_next    = {1'b0, hold_run} + 9'd1;
    stall_hit    = (hold_next >= {1'b0, LIMIT});
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_INIT:  state_nxt = ST_RUN;
      ST_RUN:   if (!step_legal) state_nxt = ST_FAULT;
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_INIT;
      q_d     <= 4'h0;
    end else begin
      state_q <= state_nxt;
      q_d     <= mon.q_in;
    end
  end

  // Display follows the input with one cycle of latency in every state.
  always_ff @(posedge clk) begin
    if (clr)
      mon.seg <= SEG_OFF;
    else if (SEG_ACTIVE_LOW != 0)
      mon.seg <= ~hex_decode(mon.q_in);
    else
      mon.seg <= hex_decode(mon.q_in);
  end

  // Wrap detection and saturating wrap count.
  always_ff @(posedge clk) begin
    if (clr) begin
      mon.wrap_pulse <= 1'b0;
      mon.wrap_cnt   <= '0;
    end else begin
      mon.wrap_pulse <= checking && step_wrap;
      if (checking && step_wrap && (mon.wrap_cnt != WRAP_MAX))
        mon.wrap_cnt <= mon.wrap_cnt + 1'b1;
    end
  end

  // Sticky error flag and saturating error count; keep running in FAULT.
  always_ff @(posedge clk) begin
    if (clr) begin
      mon.seq_err <= 1'b0;
      mon.err_cnt <= 8'h00;
    end else if (checking && !step_legal) begin
      mon.seq_err <= 1'b1;
      if (mon.err_cnt != ERR_MAX)
        mon.err_cnt <= mon.err_cnt + 8'd1;
    end
  end

  // Hold-run tracking: stall rises on the STALL_LIMIT-th consecutive hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      hold_run  <= 8'h00;
      mon.stall <= 1'b0;
    end else if (checking) begin
      if (step_hold) begin
        mon.stall <= stall_hit;
        if (hold_run < LIMIT)
          hold_run <= hold_next[7:0];
      end else begin
        mon.stall <= 1'b0;
        hold_run  <= 8'h00;
      end
    end
  end

  assign mon.state = state_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Scoreboard bench: three monitor configurations share one q_in stream; a behavioural
// model pushes expected outputs per edge and the post-edge sample pops and compares.
module tb_counter_monitor;

  typedef struct {
    int  stall_limit;
    int  wrap_max;
    bit  allow_hold;
    bit  seg_low;
  } cfg_t;

  typedef struct {
    int seg;
    int wrap_pulse;
    int wrap_cnt;
    int seq_err;
    int err_cnt;
    int stall;
    int state;
    int q_d;
    int hold_run;
  } mstate_t;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] q_drv = 4'h0;

  int checks   = 0;
  int failures = 0;

  cfg_t    cfg [3];
  mstate_t mdl [3];
  mstate_t sb  [$];

  counter_monitor_if #(.WRAP_W(16)) if_a ();
  counter_monitor_if #(.WRAP_W(16)) if_b ();
  counter_monitor_if #(.WRAP_W(2))  if_c ();

  assign if_a.q_in = q_drv;
  assign if_b.q_in = q_drv;
  assign if_c.q_in = q_drv;

  counter_monitor #(.STALL_LIMIT(8), .WRAP_W(16), .ALLOW_HOLD(1), .SEG_ACTIVE_LOW(1))
    dut_a (.clk(clk), .clr(clr), .mon(if_a));
  counter_monitor #(.STALL_LIMIT(8), .WRAP_W(16), .ALLOW_HOLD(0), .SEG_ACTIVE_LOW(0))
    dut_b (.clk(clk), .clr(clr), .mon(if_b));
  counter_monitor #(.STALL_LIMIT(1), .WRAP_W(2), .ALLOW_HOLD(1), .SEG_ACTIVE_LOW(1))
    dut_c (.clk(clk), .clr(clr), .mon(if_c));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int glyph(input int v);
    int t [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                   'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
    return t[v];
  endfunction

  function automatic mstate_t mstep(input cfg_t c, input mstate_t s, input bit r, input int q);
    mstate_t n;
    bit hold, wrap, inc, rst0, bad;
    n = s;
    if (r) begin
      n = '{seg: (c.seg_low ? 'h7F : 0), wrap_pulse: 0, wrap_cnt: 0, seq_err: 0,
            err_cnt: 0, stall: 0, state: 0, q_d: 0, hold_run: 0};
      return n;
    end
    n.seg        = c.seg_low ? ('h7F ^ glyph(q)) : glyph(q);
    n.q_d        = q;
    n.wrap_pulse = 0;
    if (s.state == 0) begin
      n.state = 1;
      return n;
    end
    hold = (q == s.q_d);
    wrap = (s.q_d == 15) && (q == 0);
    inc  = (q == s.q_d + 1);
    rst0 = (q == 0) && !hold && !wrap;
    bad  = hold ? !c.allow_hold : !(wrap || inc || rst0);
    if (wrap) begin
      n.wrap_pulse = 1;
      if (s.wrap_cnt < c.wrap_max) n.wrap_cnt = s.wrap_cnt + 1;
    end
    if (bad) begin
      n.seq_err = 1;
      if (s.err_cnt < 255) n.err_cnt = s.err_cnt + 1;
      if (s.state == 1) n.state = 2;
    end
    if (hold) begin
      n.stall    = (s.hold_run + 1 >= c.stall_limit) ? 1 : 0;
      n.hold_run = (s.hold_run + 1 > c.stall_limit) ? c.stall_limit : s.hold_run + 1;
    end else begin
      n.stall    = 0;
      n.hold_run = 0;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare(input string nm, input mstate_t e,
                         input logic [6:0] seg, input logic wp, input logic [31:0] wc,
                         input logic se, input logic [7:0] ec, input logic st,
                         input logic [1:0] fsm);
    check({nm, ".seg"},        32'(seg), 32'(e.seg));
    check({nm, ".wrap_pulse"}, 32'(wp),  32'(e.wrap_pulse));
    check({nm, ".wrap_cnt"},   wc,       32'(e.wrap_cnt));
    check({nm, ".seq_err"},    32'(se),  32'(e.seq_err));
    check({nm, ".err_cnt"},    32'(ec),  32'(e.err_cnt));
    check({nm, ".stall"},      32'(st),  32'(e.stall));
    check({nm, ".state"},      32'(fsm), 32'(e.state));
  endtask

  task automatic apply(input bit r, input int q);
    @(negedge clk);
    clr   = r;
    q_drv = 4'(q);
    for (int i = 0; i < 3; i++) begin
      mdl[i] = mstep(cfg[i], mdl[i], r, q);
      sb.push_back(mdl[i]);
    end
    @(posedge clk);
    #1;
    if (sb.size() != 3) begin
      check("sb.depth", 32'(sb.size()), 32'd3);
    end else begin
      compare("a", sb.pop_front(), if_a.seg, if_a.wrap_pulse, 32'(if_a.wrap_cnt),
              if_a.seq_err, if_a.err_cnt, if_a.stall, if_a.state);
      compare("b", sb.pop_front(), if_b.seg, if_b.wrap_pulse, 32'(if_b.wrap_cnt),
              if_b.seq_err, if_b.err_cnt, if_b.stall, if_b.state);
      compare("c", sb.pop_front(), if_c.seg, if_c.wrap_pulse, 32'(if_c.wrap_cnt),
              if_c.seq_err, if_c.err_cnt, if_c.stall, if_c.state);
    end
  endtask

  task automatic count_wraps(input int n);
    for (int w = 0; w < n; w++)
      for (int v = 0; v < 16; v++) apply(0, v);
  endtask

  initial begin
    int last;
    int pick;
    int seqv [6] = '{9, 0, 1, 2, 3, 0};

    cfg[0] = '{stall_limit: 8, wrap_max: 65535, allow_hold: 1, seg_low: 1};
    cfg[1] = '{stall_limit: 8, wrap_max: 65535, allow_hold: 0, seg_low: 0};
    cfg[2] = '{stall_limit: 1, wrap_max: 3,     allow_hold: 1, seg_low: 1};
    for (int i = 0; i < 3; i++) mdl[i] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Full count with one wrap.
    apply(1, 0);
    count_wraps(1);
    apply(0, 0);
    apply(0, 1);

    // Illegal jump, then legal steps while parked in FAULT.
    apply(1, 0);
    for (int v = 1; v <= 3; v++) apply(0, v);
    apply(0, 7);
    apply(0, 8);
    apply(0, 9);

    // Stall: hold at 5 for ten comparisons, then release.
    apply(1, 0);
    for (int k = 0; k < 11; k++) apply(0, 5);
    apply(0, 6);
    apply(0, 7);

    // Upstream restarts to zero.
    apply(1, 0);
    for (int k = 0; k < 6; k++) apply(0, seqv[k]);

    // Three wraps, a fault, mid-run clear, first post-clear sample 11.
    apply(1, 0);
    count_wraps(3);
    apply(0, 0);
    apply(0, 9);
    apply(0, 10);
    apply(1, 3);
    apply(0, 11);
    apply(0, 12);

    // Wrap counter saturation on the narrow instance.
    apply(1, 0);
    count_wraps(5);
    apply(0, 0);

    // Long hold: hold_run and err_cnt saturation.
    apply(1, 0);
    apply(0, 0);
    for (int k = 0; k < 262; k++) apply(0, 0);
    apply(0, 1);

    // Random mix of increments, holds, restarts, jumps and clears.
    apply(1, 0);
    last = 0;
    for (int k = 0; k < 300; k++) begin
      pick = $urandom_range(99);
      if (pick < 55)      last = (last + 1) % 16;
      else if (pick < 70) last = last;
      else if (pick < 80) last = 0;
      else                last = $urandom_range(15);
      apply(pick == 99 || pick == 98, last);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
